// File: rtl/gray_conv_arbiter_if.sv
// Requester/consumer bus for the shared Gray-to-binary converter.
// The master side is the environment: it drives the Gray words and accepts results.
// The slave side is the converter: it grants requesters and presents results.
interface gray_conv_arbiter_if #(
  parameter int W    = 16,
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*W-1:0] req_gray;
  logic [NREQ-1:0]   req_ready;
  logic              out_valid;
  logic [W-1:0]      out_bin;
  logic [IDW-1:0]    out_id;
  logic              out_ready;

  modport master (
    output req_valid,
    output req_gray,
    output out_ready,
    input  req_ready,
    input  out_valid,
    input  out_bin,
    input  out_id
  );

  modport slave (
    input  req_valid,
    input  req_gray,
    input  out_ready,
    output req_ready,
    output out_valid,
    output out_bin,
    output out_id
  );
endinterface

// File: rtl/gray_conv_arbiter.sv
// Round-robin shared Gray-to-binary converter.
// One word is in flight at a time: IDLE grants a requester and latches its word,
// CONV converts it into the output register, and HOLD presents the result until
// the consumer accepts it. Each result carries the index of its requester.
module gray_conv_arbiter #(
  parameter int W    = 16,
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  gray_conv_arbiter_if.slave bus,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [IDW-1:0]  rr_ptr;
  logic [IDW-1:0]  winner;
  logic            any_valid;
  logic [NREQ-1:0] grant;
  logic            take;
  logic            present;
  logic            release_out;
  logic [W-1:0]    gray_q;
  logic [IDW-1:0]  id_q;
  logic [W-1:0]    out_bin_q;
  logic [IDW-1:0]  out_id_q;
  logic            out_valid_q;
  logic [W-1:0]    gray_arr [NREQ];

  // Prefix XOR from the MSB down: each binary bit is the parity of all Gray bits at or above it.
  function automatic logic [W-1:0] gray2bin(input logic [W-1:0] g);
    logic [W-1:0] b;
    b[W-1] = g[W-1];
    for (int i = W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Modulo-NREQ increment so the pointer stays a legal requester index for any NREQ.
  function automatic logic [IDW-1:0] wrap_inc(input logic [IDW-1:0] p);
    logic [IDW-1:0] n;
    if (p == IDW'(NREQ - 1)) begin
      n = '0;
    end else begin
      n = p + 1'b1;
    end
    return n;
  endfunction

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign gray_arr[i] = bus.req_gray[i*W +: W];
  end

  // Round-robin search: first valid requester starting at rr_ptr, wrapping modulo NREQ.
  always_comb begin : pick
    logic [IDW:0]   sum;
    logic [IDW-1:0] idx;
    any_valid = 1'b0;
    winner    = '0;
    sum       = '0;
    idx       = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, rr_ptr} + (IDW+1)'(k);
      if (sum >= (IDW+1)'(NREQ)) begin
        sum = sum - (IDW+1)'(NREQ);
      end
      idx = sum[IDW-1:0];
      if (!any_valid && bus.req_valid[idx]) begin
        any_valid = 1'b1;
        winner    = idx;
      end
    end
  end

  // Next-state and strobes: grant only from IDLE, convert once, hold until accepted.
  always_comb begin
    state_nxt   = state;
    grant       = '0;
    take        = 1'b0;
    present     = 1'b0;
    release_out = 1'b0;
    unique case (state)
      IDLE: begin
        if (any_valid) begin
          grant[winner] = 1'b1;
          take          = 1'b1;
          state_nxt     = CONV;
        end
      end
      CONV: begin
        present   = 1'b1;
        state_nxt = HOLD;
      end
      HOLD: begin
        if (bus.out_ready) begin
          release_out = 1'b1;
          state_nxt   = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Grant side: latch the winner's word and ID, and move the pointer just past the winner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
      gray_q <= '0;
      id_q   <= '0;
    end else if (take) begin
      rr_ptr <= wrap_inc(winner);
      gray_q <= gray_arr[winner];
      id_q   <= winner;
    end
  end

  // Result register: loaded from the converter in CONV, frozen through HOLD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_bin_q <= '0;
      out_id_q  <= '0;
    end else if (present) begin
      out_bin_q <= gray2bin(gray_q);
      out_id_q  <= id_q;
    end
  end

  // Result valid flag: raised with the result, dropped once the consumer takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
    end else if (present) begin
      out_valid_q <= 1'b1;
    end else if (release_out) begin
      out_valid_q <= 1'b0;
    end
  end

  // Grants are forced low while reset is asserted, even if requesters are valid.
  assign bus.req_ready = rst_n ? grant : '0;
  assign bus.out_valid = out_valid_q;
  assign bus.out_bin   = out_bin_q;
  assign bus.out_id    = out_id_q;
  assign busy          = (state != IDLE);

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// Bench for gray_conv_arbiter: directed scenarios with a result scoreboard.
module tb_gray_conv_arbiter;
  localparam int W    = 16;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [W-1:0]   bin;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;
  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];
  exp_t mon_e;

  gray_conv_arbiter_if #(.W(W), .NREQ(NREQ), .IDW(IDW)) bus ();

  gray_conv_arbiter #(.W(W), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus),
    .busy (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: binary bit i is the parity of Gray bits i..W-1.
  function automatic logic [W-1:0] model_bin(input logic [W-1:0] g);
    logic [W-1:0] b;
    for (int i = 0; i < W; i++) b[i] = ^(g >> i);
    return b;
  endfunction

  function automatic exp_t mk(input logic [IDW-1:0] id, input logic [W-1:0] bin);
    exp_t e;
    e.id  = id;
    e.bin = bin;
    return e;
  endfunction

  // Scoreboard: every accepted result is compared with the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL sb_unexpected: got id=%0d bin=%h, required no result", bus.out_id, bus.out_bin);
      end else begin
        mon_e = sb.pop_front();
        if (bus.out_bin !== mon_e.bin || bus.out_id !== mon_e.id) begin
          fails++;
          $display("FAIL sb_result: got id=%0d bin=%h, required id=%0d bin=%h",
                   bus.out_id, bus.out_bin, mon_e.id, mon_e.bin);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_gray(input int r, input logic [W-1:0] g);
    bus.req_gray[r*W +: W] = g;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.req_valid = '0;
    bus.req_gray = '0;
    bus.out_ready = 1'b1;
    sb.delete();
    repeat (2) step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic wait_grant(input int budget, output logic [NREQ-1:0] g, output int waited);
    g = '0;
    waited = 0;
    for (int i = 0; i < budget; i++) begin
      #1;
      if (bus.req_ready != '0) begin
        g = bus.req_ready;
        waited = i;
        return;
      end
      step();
    end
  endtask

  task automatic drain();
    int i;
    i = 0;
    while (i < 60 && (sb.size() != 0 || busy)) begin
      step();
      i++;
    end
    tests++;
    if (sb.size() != 0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL drain: pending=%0d busy=%b, required pending=0 busy=0", sb.size(), busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.req_valid = '1;
    bus.req_gray = {16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0};
    bus.out_ready = 1'b1;
    #3;
    tests++;
    if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL rst_out_valid: got %b, required 0", bus.out_valid); end
    tests++;
    if (bus.out_bin !== 16'h0000) begin fails++; $display("FAIL rst_out_bin: got %h, required 0000", bus.out_bin); end
    tests++;
    if (bus.out_id !== 2'd0) begin fails++; $display("FAIL rst_out_id: got %0d, required 0", bus.out_id); end
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b, required 0", busy); end
    repeat (2) step();
    tests++;
    if (bus.req_ready !== 4'b0000) begin fails++; $display("FAIL rst_req_ready: got %b, required 0000", bus.req_ready); end
    bus.req_valid = '0;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single();
    logic [NREQ-1:0] g;
    int w;
    do_reset();
    set_gray(0, 16'h8000);
    bus.req_valid = 4'b0001;
    wait_grant(10, g, w);
    tests++;
    if (g !== 4'b0001) begin fails++; $display("FAIL single_grant: got %b, required 0001", g); end
    sb.push_back(mk(2'd0, 16'hFFFF));
    step();
    #1;
    tests++;
    if (bus.req_ready !== 4'b0000 || bus.out_valid !== 1'b0) begin
      fails++;
      $display("FAIL single_conv: got req_ready=%b out_valid=%b, required 0000/0", bus.req_ready, bus.out_valid);
    end
    bus.req_valid = '0;
    step();
    tests++;
    if (bus.out_valid !== 1'b1 || bus.out_bin !== 16'hFFFF || bus.out_id !== 2'd0) begin
      fails++;
      $display("FAIL single_latency: got valid=%b bin=%h id=%0d, required 1/ffff/0",
               bus.out_valid, bus.out_bin, bus.out_id);
    end
    drain();
  endtask

  task automatic test_vectors();
    logic [W-1:0] gin [5];
    logic [W-1:0] gout [5];
    logic [NREQ-1:0] g;
    int w;
    gin[0] = 16'h0000; gout[0] = 16'h0000;
    gin[1] = 16'h0003; gout[1] = 16'h0002;
    gin[2] = 16'hC000; gout[2] = 16'h8000;
    gin[3] = 16'h0001; gout[3] = 16'h0001;
    gin[4] = 16'hFFFF; gout[4] = 16'hAAAA;
    do_reset();
    for (int n = 0; n < 5; n++) begin
      set_gray(2, gin[n]);
      bus.req_valid = 4'b0100;
      wait_grant(10, g, w);
      tests++;
      if (g !== 4'b0100) begin fails++; $display("FAIL vec_grant[%0d]: got %b, required 0100", n, g); end
      sb.push_back(mk(2'd2, gout[n]));
      step();
      bus.req_valid = '0;
      drain();
    end
  endtask

  task automatic test_round_robin();
    logic [W-1:0] gr [NREQ];
    logic [NREQ-1:0] g;
    logic [NREQ-1:0] exp_g;
    int w;
    do_reset();
    for (int r = 0; r < NREQ; r++) begin
      gr[r] = W'($urandom);
      set_gray(r, gr[r]);
    end
    bus.out_ready = 1'b1;
    bus.req_valid = 4'b1111;
    for (int n = 0; n < 6; n++) begin
      exp_g = 4'(1 << (n % NREQ));
      wait_grant(12, g, w);
      tests++;
      if (g !== exp_g) begin fails++; $display("FAIL rr_grant[%0d]: got %b, required %b", n, g, exp_g); end
      if (n > 0) begin
        tests++;
        if (w !== 2) begin fails++; $display("FAIL rr_spacing[%0d]: got %0d idle cycles, required 2", n, w); end
      end
      sb.push_back(mk(IDW'(n % NREQ), model_bin(gr[n % NREQ])));
      step();
    end
    bus.req_valid = '0;
    drain();
  endtask

  task automatic test_backpressure();
    logic [W-1:0] g1;
    logic [W-1:0] g3;
    logic [NREQ-1:0] g;
    int w;
    int i;
    do_reset();
    g1 = W'($urandom);
    g3 = W'($urandom);
    set_gray(1, g1);
    set_gray(3, g3);
    bus.out_ready = 1'b0;
    bus.req_valid = 4'b1010;
    wait_grant(10, g, w);
    tests++;
    if (g !== 4'b0010) begin fails++; $display("FAIL bp_grant: got %b, required 0010", g); end
    sb.push_back(mk(2'd1, model_bin(g1)));
    step();
    bus.req_valid = 4'b1000;
    i = 0;
    while (!bus.out_valid && i < 5) begin
      step();
      i++;
    end
    for (int c = 0; c < 10; c++) begin
      #1;
      tests++;
      if (bus.out_valid !== 1'b1 || bus.out_bin !== model_bin(g1) || bus.out_id !== 2'd1 ||
          bus.req_ready !== 4'b0000) begin
        fails++;
        $display("FAIL bp_hold[%0d]: got valid=%b bin=%h id=%0d rdy=%b, required 1/%h/1/0000",
                 c, bus.out_valid, bus.out_bin, bus.out_id, bus.req_ready, model_bin(g1));
      end
      step();
    end
    bus.out_ready = 1'b1;
    step();
    tests++;
    if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL bp_release: got out_valid=%b, required 0", bus.out_valid); end
    wait_grant(1, g, w);
    tests++;
    if (g !== 4'b1000) begin fails++; $display("FAIL bp_next_grant: got %b, required 1000", g); end
    sb.push_back(mk(2'd3, model_bin(g3)));
    step();
    bus.req_valid = '0;
    drain();
  endtask

  task automatic test_skip();
    logic [W-1:0] g0;
    logic [W-1:0] g3;
    logic [NREQ-1:0] g;
    int w;
    do_reset();
    g0 = W'($urandom);
    g3 = W'($urandom);
    set_gray(0, g0);
    set_gray(3, g3);
    bus.req_valid = 4'b0001;
    wait_grant(10, g, w);
    tests++;
    if (g !== 4'b0001) begin fails++; $display("FAIL skip_setup: got %b, required 0001", g); end
    sb.push_back(mk(2'd0, model_bin(g0)));
    step();
    bus.req_valid = '0;
    drain();
    bus.req_valid = 4'b1001;
    wait_grant(10, g, w);
    tests++;
    if (g !== 4'b1000) begin fails++; $display("FAIL skip_grant3: got %b, required 1000", g); end
    sb.push_back(mk(2'd3, model_bin(g3)));
    step();
    wait_grant(10, g, w);
    tests++;
    if (g !== 4'b0001) begin fails++; $display("FAIL skip_wrap0: got %b, required 0001", g); end
    sb.push_back(mk(2'd0, model_bin(g0)));
    step();
    bus.req_valid = '0;
    drain();
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] g1;
    logic [NREQ-1:0] g;
    int w;
    int i;
    do_reset();
    g1 = W'($urandom);
    set_gray(2, 16'h5A5A);
    set_gray(1, g1);
    bus.out_ready = 1'b0;
    bus.req_valid = 4'b0100;
    wait_grant(10, g, w);
    tests++;
    if (g !== 4'b0100) begin fails++; $display("FAIL rm_grant: got %b, required 0100", g); end
    sb.push_back(mk(2'd2, model_bin(16'h5A5A)));
    step();
    bus.req_valid = '0;
    i = 0;
    while (!bus.out_valid && i < 5) begin
      step();
      i++;
    end
    tests++;
    if (bus.out_valid !== 1'b1 || busy !== 1'b1) begin
      fails++;
      $display("FAIL rm_hold: got out_valid=%b busy=%b, required 1/1", bus.out_valid, busy);
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL rm_out_valid: got %b, required 0", bus.out_valid); end
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL rm_busy: got %b, required 0", busy); end
    sb.delete();
    repeat (2) step();
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    step();
    bus.req_valid = 4'b0110;
    wait_grant(10, g, w);
    tests++;
    if (g !== 4'b0010) begin fails++; $display("FAIL rm_first_grant: got %b, required 0010", g); end
    sb.push_back(mk(2'd1, model_bin(g1)));
    step();
    bus.req_valid = '0;
    drain();
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_gray = '0;
    bus.out_ready = 1'b1;
    test_reset();
    test_single();
    test_vectors();
    test_round_robin();
    test_backpressure();
    test_skip();
    test_reset_mid();
    repeat (3) step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
